imem_load_ctrl: RTL and testbench

Boot/load controller for the 64x32 instruction memory. Accepts a stream of instruction words from a host over a valid/ready handshake and writes them sequentially from address 0. Optionally pads the remaining words with NOPs. Holds the CPU (PC/fetch) in reset until the image is committed, then releases it; a later start reloads the memory.

---
 rtl/imem_load_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//
// Boot/load controller for the instruction memory. A host streams instruction
// words over a valid/ready handshake; they are written sequentially from word
// address 0. When FILL_NOP is set, the words after the loaded image are padded
// with NOP_WORD up to DEPTH-1. The CPU (PC/fetch) is held in reset until the
// image is committed, then released. A later start reloads the memory.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   single-cycle request to begin a load
//   load_len   in   words to load (1..DEPTH), sampled on an accepted start
//   wr_valid   in   host word valid
//   wr_data    in   host instruction word
//   wr_ready   out  controller accepts a word this cycle
//   mem_we     out  instruction memory write enable
//   mem_waddr  out  instruction memory write word address
//   mem_wdata  out  instruction memory write data
//   cpu_hold   out  active-high hold/reset to PC and fetch
//   busy       out  load in progress (LOAD, PAD or FLUSH)
//   done       out  sticky: image committed, CPU running
//   err        out  sticky: last start had an illegal load_len
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter int            DEPTH    = 64,
  parameter int            AW       = 6,
  parameter int            DW       = 32,
  parameter bit            FILL_NOP = 1'b1,
  parameter logic [DW-1:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    FLUSH,
    RUN
  } state_t;

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] ONE_C   = 1;

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;

  logic          wr_ready_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_waddr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          cpu_hold_d;
  logic          busy_d;
  logic          done_d;
  logic          err_d;

  logic          len_ok;
  logic          pad_needed;

  assign len_ok     = (load_len != '0) && (load_len <= DEPTH_C);
  assign pad_needed = FILL_NOP && (len_q < DEPTH_C);

  // State and every output are registered together so the outputs always
  // describe the state the controller is in during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      wr_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wr_ready  <= wr_ready_d;
      mem_we    <= mem_we_d;
      mem_waddr <= mem_waddr_d;
      mem_wdata <= mem_wdata_d;
      cpu_hold  <= cpu_hold_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Next-state and next-output logic. mem_we defaults low so a write lasts
  // exactly one cycle; the other outputs hold unless a transition changes them.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    wr_ready_d  = wr_ready;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr;
    mem_wdata_d = mem_wdata;
    cpu_hold_d  = cpu_hold;
    busy_d      = busy;
    done_d      = done;
    err_d       = err;

    unique case (state_q)
      IDLE, RUN: begin
        if (start) begin
          if (len_ok) begin
            state_d    = LOAD;
            len_d      = load_len;
            cnt_d      = '0;
            err_d      = 1'b0;
            done_d     = 1'b0;
            cpu_hold_d = 1'b1;
            busy_d     = 1'b1;
            wr_ready_d = 1'b1;
          end else begin
            // A bad length is only flagged; a running CPU keeps running.
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (cnt_q == len_q) begin
          // Drain cycle: the last host word is on the write port now, so
          // the first pad write (if any) can be issued for the next cycle.
          if (pad_needed) begin
            state_d     = PAD;
            mem_we_d    = 1'b1;
            mem_waddr_d = cnt_q[AW-1:0];
            mem_wdata_d = NOP_WORD;
            cnt_d       = cnt_q + ONE_C;
          end else begin
            state_d = FLUSH;
          end
        end else if (wr_valid && wr_ready) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = cnt_q[AW-1:0];
          mem_wdata_d = wr_data;
          cnt_d       = cnt_q + ONE_C;
          if (cnt_q == len_q - ONE_C) begin
            wr_ready_d = 1'b0;
          end
        end
      end

      PAD: begin
        // cnt reaching DEPTH means the write to DEPTH-1 is on the port now;
        // stopping here keeps the address from wrapping back to 0.
        if (cnt_q == DEPTH_C) begin
          state_d = FLUSH;
        end else begin
          mem_we_d    = 1'b1;
          mem_waddr_d = cnt_q[AW-1:0];
          mem_wdata_d = NOP_WORD;
          cnt_d       = cnt_q + ONE_C;
        end
      end

      FLUSH: begin
        // One quiet cycle so the final write lands before the first fetch.
        state_d    = RUN;
        cpu_hold_d = 1'b0;
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_load_ctrl
//
// Drives two copies of imem_load_ctrl from the same stimulus: u_fill pads with
// NOPs, u_nofill does not. A load-level reference model predicts, from each
// accepted start and each handshake, the writes the memory should see, the
// cycle the CPU is released and the sticky flags; every cycle both copies are
// compared against it. A scenario table adds end-of-load totals (write count,
// release latency, flags), and hand sequences cover reset and restart cases.
// -----------------------------------------------------------------------------
module tb_imem_load_ctrl;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  load_len;
  logic        wr_valid;
  logic [31:0] wr_data;

  logic        rdy   [2];
  logic        we    [2];
  logic [5:0]  waddr [2];
  logic [31:0] wdata [2];
  logic        hold  [2];
  logic        busy  [2];
  logic        done  [2];
  logic        err   [2];

  imem_load_ctrl u_fill (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_len  (load_len),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (rdy[0]),
    .mem_we    (we[0]),
    .mem_waddr (waddr[0]),
    .mem_wdata (wdata[0]),
    .cpu_hold  (hold[0]),
    .busy      (busy[0]),
    .done      (done[0]),
    .err       (err[0])
  );

  imem_load_ctrl #(.FILL_NOP(1'b0)) u_nofill (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_len  (load_len),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (rdy[1]),
    .mem_we    (we[1]),
    .mem_waddr (waddr[1]),
    .mem_wdata (wdata[1]),
    .cpu_hold  (hold[1]),
    .busy      (busy[1]),
    .done      (done[1]),
    .err       (err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Cycle k is the interval right after rising edge number k.
  int n_edge = 0;

  // Reference model state, index 0 = padding copy, 1 = non-padding copy.
  bit   m_busy    [2];
  bit   m_loading [2];
  int   m_len     [2];
  int   m_cnt     [2];
  int   run_at    [2];
  int   m_hs      [2];
  logic e_ready   [2];
  logic e_hold    [2];
  logic e_busy    [2];
  logic e_done    [2];
  logic e_err     [2];

  // Expected writes keyed by cycle*2+copy: {addr[5:0], data[31:0]}.
  logic [37:0] wq [int];

  // Observations of the DUT used by the scenario table.
  int   wcount    [2];
  int   fall_cyc  [2];
  logic prev_hold [2];

  typedef struct {
    int len;
    int mode;
    bit exp_err;
    int exp_w0;
    int exp_w1;
    int exp_lat0;
    int exp_lat1;
    bit exp_done;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] fixed_words [3];

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s copy%0d cycle %0d: got %h expected %h",
               name, inst, n_edge, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulseStart(input int len);
    start    = 1'b1;
    load_len = 7'(len);
    stepCycle();
    start    = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag, "_hold"},  i, 32'(hold[i]),  32'd1);
      checkOutput({tag, "_ready"}, i, 32'(rdy[i]),   32'd0);
      checkOutput({tag, "_we"},    i, 32'(we[i]),    32'd0);
      checkOutput({tag, "_waddr"}, i, 32'(waddr[i]), 32'd0);
      checkOutput({tag, "_wdata"}, i, wdata[i],      32'd0);
      checkOutput({tag, "_busy"},  i, 32'(busy[i]),  32'd0);
      checkOutput({tag, "_done"},  i, 32'(done[i]),  32'd0);
      checkOutput({tag, "_err"},   i, 32'(err[i]),   32'd0);
    end
  endtask

  // Starts a load and feeds words until the model says all were accepted.
  // mode 0: valid every cycle, 1: valid toggles 1/0, 2: random valid,
  // 3: back-to-back with the fixed word list. restart_at pulses start
  // (len 3) once that many words have been accepted.
  task automatic applyStimulus(input int len, input int mode, input int restart_at);
    int  guard;
    bit  tog;
    bit  restarted;
    for (int i = 0; i < 2; i++) begin
      wcount[i]   = 0;
      fall_cyc[i] = -1;
    end
    pulseStart(len);
    guard     = 0;
    tog       = 1'b1;
    restarted = 1'b0;
    while (m_busy[0] && m_loading[0] && guard < 1000) begin
      case (mode)
        1:       begin wr_valid = tog; tog = ~tog; end
        2:       wr_valid = 1'($urandom_range(0, 1));
        default: wr_valid = 1'b1;
      endcase
      wr_data = (mode == 3) ? fixed_words[m_cnt[0] % 3] : $urandom;
      if (!restarted && restart_at == m_cnt[0]) begin
        start     = 1'b1;
        load_len  = 7'd3;
        restarted = 1'b1;
      end
      stepCycle();
      start = 1'b0;
      guard++;
    end
    wr_valid = 1'b0;
    if (guard >= 1000) begin
      total++;
      bad++;
      $display("[TB] FAIL load_timeout: accepted %0d of %0d words", m_cnt[0], len);
    end
    guard = 0;
    while ((e_busy[0] || e_busy[1]) && guard < 200) begin
      stepCycle();
      guard++;
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL release_timeout: load of %0d never finished", len);
    end
    stepCycle();
  endtask

  // Reference model: advances on each rising edge from the sampled inputs.
  initial begin
    int npad;
    forever begin
      @(posedge clk);
      n_edge = n_edge + 1;
      if (rst) wq.delete();
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_busy[i]    = 1'b0;
          m_loading[i] = 1'b0;
          m_cnt[i]     = 0;
          e_ready[i]   = 1'b0;
          e_hold[i]    = 1'b1;
          e_busy[i]    = 1'b0;
          e_done[i]    = 1'b0;
          e_err[i]     = 1'b0;
        end else if (!m_busy[i]) begin
          if (start) begin
            if (load_len >= 7'd1 && int'(load_len) <= DEPTH) begin
              m_busy[i]    = 1'b1;
              m_loading[i] = 1'b1;
              m_len[i]     = int'(load_len);
              m_cnt[i]     = 0;
              e_ready[i]   = 1'b1;
              e_busy[i]    = 1'b1;
              e_hold[i]    = 1'b1;
              e_done[i]    = 1'b0;
              e_err[i]     = 1'b0;
            end else begin
              e_err[i] = 1'b1;
            end
          end
        end else if (m_loading[i]) begin
          if (wr_valid && e_ready[i]) begin
            wq[n_edge*2 + i] = {6'(m_cnt[i]), wr_data};
            m_cnt[i]++;
            if (m_cnt[i] == m_len[i]) begin
              npad = (i == 0 && m_len[i] < DEPTH) ? DEPTH - m_len[i] : 0;
              for (int k = 1; k <= npad; k++)
                wq[(n_edge + k)*2 + i] = {6'(m_len[i] + k - 1), NOP};
              m_hs[i]      = n_edge - 1;
              run_at[i]    = n_edge + npad + 2;
              e_ready[i]   = 1'b0;
              m_loading[i] = 1'b0;
            end
          end
        end else if (n_edge == run_at[i]) begin
          m_busy[i] = 1'b0;
          e_busy[i] = 1'b0;
          e_hold[i] = 1'b0;
          e_done[i] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of both copies against the model, mid-cycle.
  initial begin
    int          key;
    logic [37:0] ent;
    prev_hold[0] = 1'b1;
    prev_hold[1] = 1'b1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        key = n_edge*2 + i;
        if (prev_hold[i] === 1'b1 && hold[i] === 1'b0) fall_cyc[i] = n_edge;
        prev_hold[i] = hold[i];
        if (we[i] === 1'b1) wcount[i]++;
        checkOutput("wr_ready", i, 32'(rdy[i]), 32'(e_ready[i]));
        checkOutput("mem_we", i, 32'(we[i]), 32'(wq.exists(key)));
        if (wq.exists(key)) begin
          ent = wq[key];
          checkOutput("mem_waddr", i, 32'(waddr[i]), 32'(ent[37:32]));
          checkOutput("mem_wdata", i, wdata[i], ent[31:0]);
          wq.delete(key);
        end
        checkOutput("cpu_hold", i, 32'(hold[i]), 32'(e_hold[i]));
        checkOutput("busy", i, 32'(busy[i]), 32'(e_busy[i]));
        checkOutput("done", i, 32'(done[i]), 32'(e_done[i]));
        checkOutput("err", i, 32'(err[i]), 32'(e_err[i]));
      end
    end
  end

  initial begin
    int guard;
    int len;

    fixed_words[0] = 32'h00002303;
    fixed_words[1] = 32'h00402383;
    fixed_words[2] = 32'h00802E03;

    //          len mode err w_fill w_nofill lat_fill lat_nofill done
    tbl[0] = '{ 3,   3,  1'b0, 64,  3,  64, 3,  1'b1};
    tbl[1] = '{ 64,  1,  1'b0, 64,  64, 3,  3,  1'b1};
    tbl[2] = '{ 0,   0,  1'b1, 0,   0,  -1, -1, 1'b1};
    tbl[3] = '{ 65,  0,  1'b1, 0,   0,  -1, -1, 1'b1};
    tbl[4] = '{ 2,   2,  1'b0, 64,  2,  65, 3,  1'b1};
    tbl[5] = '{ 63,  2,  1'b0, 64,  63, 4,  3,  1'b1};
    tbl[6] = '{ 1,   0,  1'b0, 64,  1,  66, 3,  1'b1};
    tbl[7] = '{ 127, 0,  1'b1, 0,   0,  -1, -1, 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    load_len = '0;
    wr_valid = 1'b0;
    wr_data  = '0;
    repeat (3) stepCycle();
    checkReset("reset");

    // Idle after reset: nothing may move for 20 cycles.
    rst = 1'b0;
    wcount[0] = 0;
    wcount[1] = 0;
    repeat (20) stepCycle();
    checkReset("idle20");
    checkOutput("idle_writes", 0, 32'(wcount[0]), 32'd0);

    // Illegal lengths from IDLE flag err and keep the CPU held.
    pulseStart(0);
    stepCycle();
    checkOutput("len0_err", 0, 32'(err[0]), 32'd1);
    checkOutput("len0_hold", 0, 32'(hold[0]), 32'd1);
    pulseStart(65);
    stepCycle();
    checkOutput("len65_err", 1, 32'(err[1]), 32'd1);
    checkOutput("len65_busy", 1, 32'(busy[1]), 32'd0);
    applyStimulus(2, 0, -1);
    checkOutput("err_cleared", 0, 32'(err[0]), 32'd0);
    checkOutput("len2_done", 0, 32'(done[0]), 32'd1);

    // Scenario table.
    for (int r = 0; r < 8; r++) begin
      applyStimulus(tbl[r].len, tbl[r].mode, -1);
      checkOutput("tbl_writes", 0, 32'(wcount[0]), 32'(tbl[r].exp_w0));
      checkOutput("tbl_writes", 1, 32'(wcount[1]), 32'(tbl[r].exp_w1));
      checkOutput("tbl_err", 0, 32'(err[0]), 32'(tbl[r].exp_err));
      checkOutput("tbl_done", 1, 32'(done[1]), 32'(tbl[r].exp_done));
      checkOutput("tbl_hold", 0, 32'(hold[0]), 32'(!tbl[r].exp_done));
      if (!tbl[r].exp_err) begin
        checkOutput("tbl_latency", 0, 32'(fall_cyc[0] - m_hs[0]), 32'(tbl[r].exp_lat0));
        checkOutput("tbl_latency", 1, 32'(fall_cyc[1] - m_hs[1]), 32'(tbl[r].exp_lat1));
      end
    end

    // Reset after 5 of 10 words, with start also high: reset wins.
    pulseStart(10);
    guard = 0;
    wr_valid = 1'b1;
    while (m_cnt[0] < 5 && guard < 100) begin
      wr_data = $urandom;
      stepCycle();
      guard++;
    end
    wr_valid = 1'b0;
    rst      = 1'b1;
    start    = 1'b1;
    load_len = 7'd4;
    stepCycle();
    checkReset("midload_rst");
    rst   = 1'b0;
    start = 1'b0;
    stepCycle();
    checkReset("after_rst");
    applyStimulus(10, 2, -1);
    checkOutput("reload_writes", 1, 32'(wcount[1]), 32'd10);

    // Reload from RUN: the CPU is held again on the very next cycle.
    pulseStart(1);
    checkOutput("rerun_hold", 0, 32'(hold[0]), 32'd1);
    checkOutput("rerun_done", 1, 32'(done[1]), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 32'h0000006F;
    guard    = 0;
    while (m_loading[0] && guard < 50) begin
      stepCycle();
      guard++;
    end
    wr_valid = 1'b0;
    repeat (70) stepCycle();
    checkOutput("rerun_done_end", 0, 32'(done[0]), 32'd1);

    // A start pulse in the middle of a load changes nothing.
    applyStimulus(8, 2, 3);
    checkOutput("restart_writes", 0, 32'(wcount[0]), 32'd64);
    checkOutput("restart_writes", 1, 32'(wcount[1]), 32'd8);

    // Random loads, including illegal lengths, against the model.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(0, 68);
      applyStimulus(len, 2, -1);
    end

    repeat (3) stepCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
